vga_letter_sequencer: RTL
=========================

Name: vga_letter_sequencer

Overview:
- Controller in front of the per-glyph letter-to-pixel renderer.
- Stores a message of 5-bit letter codes and presents a scrolling window of WIN codes, one per on-screen glyph renderer.
- Generates the renderer's effect controls (valid tick, steady/shine/ambiant) from a timed effect state machine, and holds the theme register.
- Sits between the button/keyboard front end and the glyph renderers, on the VGA pixel clock.

Parameters:
TICK_DIV, 2500000, clk cycles per effect tick; valid pulses once per tick.
MSG_DEPTH, 16, message buffer entries; must be a power of 2.
WIN, 4, glyph slots presented on letters.
STEADY_TICKS, 20, ticks spent in STEADY per effect loop.
SHINE_TICKS, 8, ticks spent in SHINE per effect loop.
AMB_TICKS, 16, ticks spent in AMB per effect loop.
SCROLL_TICKS, 5, ticks per one-position scroll.

Ports:
clk  in  1  pixel-domain clock.
rst  in  1  asynchronous reset, active-high.
start  in  1  one-cycle pulse; begins the sequence.
stop  in  1  one-cycle pulse; aborts to IDLE.
theme_next  in  1  one-cycle pulse; advances the theme.
wr_en  in  1  message write strobe.
wr_addr  in  log2(MSG_DEPTH)  message write index.
wr_data  in  5  letter code to write.
msg_len  in  5  message length; sampled on an accepted start.
letters  out  5*WIN  slot k occupies bits [5k+4:5k]; slot 0 is leftmost.
theme  out  4  renderer theme, 0..2.
steady  out  1  renderer steady control.
shine  out  1  renderer shine control.
ambiant  out  1  renderer ambient-fade control.
valid  out  1  one-cycle effect tick.
busy  out  1  high in any state other than IDLE.
frame_done  out  1  one-cycle pulse when the scroll position wraps to 0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; tick, phase and scroll counters = 0; pos=0.
  - letters all 5'd31 (blank code, renders as background); theme=0; steady=1; shine=0; ambiant=0; valid=0; busy=0; frame_done=0.
  - Message memory is not reset.
  - Reset asserted mid-operation aborts immediately to this state.
- Message write: when wr_en=1, mem[wr_addr] <= wr_data in every state. A write is visible on letters 1 cycle later if that entry is in the window.
- Start acceptance: start is accepted only in IDLE with msg_len != 0.
  - len latched as min(msg_len, MSG_DEPTH); pos=0; next state STEADY.
  - start in IDLE with msg_len=0 is ignored.
  - start in any running state is ignored.
- Stop: any running state -> IDLE next cycle. If stop and start arrive in the same cycle, stop wins.
- Tick counter:
  - Runs only when busy; counts 0..TICK_DIV-1 and wraps.
  - valid=1 for exactly the cycle after the count reaches TICK_DIV-1 (registered). First valid occurs TICK_DIV cycles after entering STEADY.
  - In IDLE the counter is held at 0 and valid=0.
- Effect FSM, advanced on valid:
  - The phase counter increments per tick.
  - STEADY -> SHINE after STEADY_TICKS ticks; SHINE -> AMB after SHINE_TICKS; AMB -> STEADY after AMB_TICKS, looping until stop.
  - The phase counter clears on every transition.
- Registered outputs (state + 1 cycle):
  - steady = (state==STEADY or IDLE); shine = (state==SHINE); ambiant = (state==AMB).
  - At most one of steady/shine/ambiant is ever high.
- Scroll:
  - The scroll counter increments per tick in all running states.
  - At SCROLL_TICKS it clears and pos <= (pos+1) mod len.
  - frame_done pulses for 1 cycle when pos goes len-1 -> 0. With len=1 it pulses every scroll.
- Window (registered, 1-cycle latency):
  - While busy: slot k = mem[(pos+k) mod len] for k < len; slot k = 5'd31 for k >= len.
  - In IDLE: all slots 5'd31.
- Theme: theme_next advances 0->1->2->0 in any state, including IDLE. Not affected by stop.
- Width rules: (pos+k) mod len is computed without a divider (compare-and-subtract), since pos+k < 2*MSG_DEPTH.

Test Plan (TICK_DIV=4, STEADY_TICKS=2, SHINE_TICKS=2, AMB_TICKS=3, SCROLL_TICKS=1, WIN=4):
1. Reset mid-run, then release -> letters=20'hFFFFF, steady=1, busy=0, theme=0; no valid for 20 cycles.
2. Write mem[0..5]={0,1,2,4,6,8}, msg_len=6, start:
   - valid every 4 cycles.
   - letters slots 0..3 = {0,1,2,4}, then {1,2,4,6} after the first tick.
   - frame_done after 6 ticks, with pos back to 0.
3. Effect loop -> steady for 2 ticks, shine for 2, ambiant for 3, then steady again; never two controls high in the same cycle.
4. msg_len=2 with mem {7,8} -> slots = {7,8,31,31}, then {8,7,31,31}; frame_done every 2 ticks.
5. start with msg_len=0 -> stays IDLE. start and stop in the same cycle while IDLE -> stays IDLE. stop during SHINE -> IDLE next cycle, shine=0, steady=1, letters blank.
6. theme_next x4 -> theme 1,2,0,1. wr_en to an entry currently in slot 0 -> letters slot 0 updates exactly 1 cycle later.

Source files
------------

// File: rtl/vga_letter_sequencer.sv
// Letter sequencer for the glyph renderers: message buffer, scrolling window,
// effect-tick generator, timed effect FSM and theme register.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   S_IDLE   | waiting for start, window blank, steady shown
//   S_STEADY | steady effect, scrolling
//   S_SHINE  | shine effect, scrolling
//   S_AMB    | ambient-fade effect, scrolling
module vga_letter_sequencer #(
  parameter int TICK_DIV     = 2500000,
  parameter int MSG_DEPTH    = 16,
  parameter int WIN          = 4,
  parameter int STEADY_TICKS = 20,
  parameter int SHINE_TICKS  = 8,
  parameter int AMB_TICKS    = 16,
  parameter int SCROLL_TICKS = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         theme_next,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [4:0]                   wr_data,
  input  logic [4:0]                   msg_len,
  output logic [5*WIN-1:0]             letters,
  output logic [3:0]                   theme,
  output logic                         steady,
  output logic                         shine,
  output logic                         ambiant,
  output logic                         valid,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = 8;
  localparam int SW = 8;
  localparam logic [4:0] BLANK = 5'd31;
  localparam logic [5:0] DEPTH6 = 6'(MSG_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_STEADY, S_SHINE, S_AMB} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   phase, phase_d;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   scroll_cnt;
  logic [AW-1:0]   pos;
  logic [LW-1:0]   len, len_in;
  logic [4:0]      mem [MSG_DEPTH];
  logic [5*WIN-1:0] window;
  logic            running, accept;

  assign running = (state != S_IDLE);
  assign busy    = running;
  // stop has priority over start, even in IDLE
  assign accept  = (state == S_IDLE) && start && !stop && (msg_len != 5'd0);

  function automatic logic [PW-1:0] phase_last(state_t s);
    case (s)
      S_STEADY: return PW'(STEADY_TICKS - 1);
      S_SHINE:  return PW'(SHINE_TICKS - 1);
      default:  return PW'(AMB_TICKS - 1);
    endcase
  endfunction

  // Clamp requested length to the buffer depth
  always_comb begin
    len_in = LW'(MSG_DEPTH);
    if ({1'b0, msg_len} <= DEPTH6) len_in = LW'(msg_len);
  end

  // State and phase registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      phase <= '0;
    end else begin
      state <= state_d;
      phase <= phase_d;
    end
  end

  // Next-state logic: effect phases advance on each tick
  always_comb begin
    state_d = state;
    phase_d = phase;
    if (!running) begin
      phase_d = '0;
      if (accept) state_d = S_STEADY;
    end else if (stop) begin
      state_d = S_IDLE;
      phase_d = '0;
    end else if (valid) begin
      if (phase == phase_last(state)) begin
        phase_d = '0;
        case (state)
          S_STEADY: state_d = S_SHINE;
          S_SHINE:  state_d = S_AMB;
          default:  state_d = S_STEADY;
        endcase
      end else begin
        phase_d = phase + PW'(1);
      end
    end
  end

  // Tick divider: valid follows the terminal count by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      valid    <= 1'b0;
    end else if (!running || stop) begin
      tick_cnt <= '0;
      valid    <= 1'b0;
    end else begin
      valid    <= (tick_cnt == TW'(TICK_DIV - 1));
      tick_cnt <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + TW'(1);
    end
  end

  // Scroll position, message length latch and wrap pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll_cnt <= '0;
      pos        <= '0;
      len        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        len        <= len_in;
        pos        <= '0;
        scroll_cnt <= '0;
      end else if (!running || stop) begin
        pos        <= '0;
        scroll_cnt <= '0;
      end else if (valid) begin
        if (scroll_cnt == SW'(SCROLL_TICKS - 1)) begin
          scroll_cnt <= '0;
          if (({1'b0, pos} + LW'(1)) >= len) begin
            pos        <= '0;
            frame_done <= 1'b1;
          end else begin
            pos <= pos + AW'(1);
          end
        end else begin
          scroll_cnt <= scroll_cnt + SW'(1);
        end
      end
    end
  end

  // Message memory, writable in every state, not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Window gather; pos+k < 2*len so one conditional subtract gives the modulo
  always_comb begin
    logic [LW-1:0] idx;
    idx    = '0;
    window = {WIN{BLANK}};
    for (int k = 0; k < WIN; k++) begin
      idx = {1'b0, pos} + LW'(k);
      if (idx >= len) idx = idx - len;
      if (LW'(k) < len) window[5*k +: 5] = mem[idx[AW-1:0]];
    end
  end

  // Registered window and effect controls (one cycle behind state)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      letters <= {WIN{BLANK}};
      steady  <= 1'b1;
      shine   <= 1'b0;
      ambiant <= 1'b0;
    end else begin
      letters <= running ? window : {WIN{BLANK}};
      steady  <= (state == S_STEADY) || (state == S_IDLE);
      shine   <= (state == S_SHINE);
      ambiant <= (state == S_AMB);
    end
  end

  // Theme cycles 0 -> 1 -> 2 -> 0, independent of the sequencer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      theme <= 4'd0;
    end else if (theme_next) begin
      theme <= (theme == 4'd2) ? 4'd0 : theme + 4'd1;
    end
  end

endmodule
